// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: two-port access arbiter for the byte-addressed data memory.
// Ports:
//   clk, rst                       clock, sync active-high reset
//   mN_req/we/addr/wdata/type      request fields, port 0 = MEM stage, port 1 = loader
//   mN_gnt                         combinational grant (accepted when req & gnt)
//   mN_done/err/rdata              registered one-cycle response to the owner
//   dm_MemWrite/MemRead/addr/din/DMType  DM access fields
//   dm_dout                        DM combinational read data
module dm_access_arbiter #(
    parameter int DEPTH        = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_type,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_type,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        dm_MemWrite,
    output logic        dm_MemRead,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [2:0]  dm_DMType,
    input  logic [31:0] dm_dout
);
    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    logic [2:0]  starve_cnt;
    logic        p1_pri;
    logic        acc;
    logic        legal;
    logic        type_ok;
    logic        misal;
    logic        oor;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_type;
    logic [2:0]  size;
    logic [32:0] last;

    logic        resp_done;
    logic        resp_own;
    logic        resp_err;
    logic [31:0] resp_rdata;

    // Port 1 overrides the default port-0 priority once it has starved.
    assign p1_pri = {29'd0, starve_cnt} >= 32'(STARVE_LIMIT);
    assign m1_gnt = ~rst & m1_req & (~m0_req | p1_pri);
    assign m0_gnt = ~rst & m0_req & ~m1_gnt;
    assign acc    = m0_gnt | m1_gnt;

    assign sel_we    = m1_gnt ? m1_we    : m0_we;
    assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign sel_type  = m1_gnt ? m1_type  : m0_type;

    always_comb begin
        type_ok = 1'b1;
        misal   = 1'b0;
        size    = 3'd1;
        case (sel_type)
            DM_WORD: begin
                size  = 3'd4;
                misal = |sel_addr[1:0];
            end
            DM_HALF, DM_HALFU: begin
                size  = 3'd2;
                misal = sel_addr[0];
            end
            DM_BYTE, DM_BYTEU: size = 3'd1;
            default: type_ok = 1'b0;
        endcase
    end

    // Last byte touched, one bit wider so addresses near 2^32 cannot wrap.
    assign last  = {1'b0, sel_addr} + {30'd0, size} - 33'd1;
    assign oor   = last > 33'(DEPTH - 1);
    assign legal = acc & type_ok & ~misal & ~oor;

    assign dm_MemWrite = legal & sel_we;
    assign dm_MemRead  = legal & ~sel_we;
    assign dm_addr     = acc ? sel_addr  : 32'd0;
    assign dm_din      = acc ? sel_wdata : 32'd0;
    assign dm_DMType   = acc ? sel_type  : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
            resp_done  <= 1'b0;
            resp_own   <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            if (m1_req & ~m1_gnt)
                starve_cnt <= (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;
            else
                starve_cnt <= 3'd0;
            resp_done  <= acc;
            resp_own   <= m1_gnt;
            resp_err   <= acc & ~legal;
            resp_rdata <= (legal & ~sel_we) ? dm_dout : 32'd0;
        end
    end

    // Gating with rst drops a response still pending when reset arrives.
    assign m0_done  = resp_done & ~resp_own & ~rst;
    assign m1_done  = resp_done &  resp_own & ~rst;
    assign m0_err   = m0_done & resp_err;
    assign m1_err   = m1_done & resp_err;
    assign m0_rdata = m0_done ? resp_rdata : 32'd0;
    assign m1_rdata = m1_done ? resp_rdata : 32'd0;
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed bench for dm_access_arbiter with a byte memory
// model; expected responses are queued at issue time and checked by a monitor.
module tb_dm_access_arbiter;
    localparam logic [2:0] W  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] HU = 3'b010;
    localparam logic [2:0] B  = 3'b011;
    localparam logic [2:0] BU = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_type, m1_type;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_MemWrite, dm_MemRead;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic [2:0]  dm_DMType;

    dm_access_arbiter #(.DEPTH(128), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_type(m0_type),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_type(m1_type),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .dm_MemWrite(dm_MemWrite), .dm_MemRead(dm_MemRead),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_DMType(dm_DMType),
        .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Data memory model with sign/zero extension on read.
    logic [7:0] mem [0:127];
    logic       mem_clr;
    logic [6:0] ra;
    logic [7:0] b0, b1, b2, b3;
    assign ra = dm_addr[6:0];
    assign b0 = mem[ra];
    assign b1 = mem[ra + 7'd1];
    assign b2 = mem[ra + 7'd2];
    assign b3 = mem[ra + 7'd3];

    always_comb begin
        dm_dout = 32'd0;
        case (dm_DMType)
            W:  dm_dout = {b3, b2, b1, b0};
            H:  dm_dout = {{16{b1[7]}}, b1, b0};
            HU: dm_dout = {16'd0, b1, b0};
            B:  dm_dout = {{24{b0[7]}}, b0};
            BU: dm_dout = {24'd0, b0};
            default: dm_dout = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'd0;
        end else if (dm_MemWrite) begin
            mem[ra] <= dm_din[7:0];
            if (dm_DMType == W || dm_DMType == H || dm_DMType == HU)
                mem[ra + 7'd1] <= dm_din[15:8];
            if (dm_DMType == W) begin
                mem[ra + 7'd2] <= dm_din[23:16];
                mem[ra + 7'd3] <= dm_din[31:24];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    function automatic void chk(string nm, logic [95:0] act, logic [95:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rd;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Monitor: every due response must appear exactly on its cycle; any
    // other done/err/rdata activity is spurious.
    always @(negedge clk) begin
        exp_t        e;
        logic [67:0] act;
        logic [67:0] want;
        act = {m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata};
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.port) want = {34'd0, 1'b1, e.err, e.rd};
            else        want = {1'b1, e.err, e.rd, 34'd0};
            chk(e.port ? "resp_m1" : "resp_m0", 96'(act), 96'(want));
        end else if (|act) begin
            chk("spurious_resp", 96'(act), 96'd0);
        end
    end

    task automatic set0(input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] t);
        m0_we = we; m0_addr = a; m0_wdata = d; m0_type = t;
    endtask

    task automatic set1(input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] t);
        m1_we = we; m1_addr = a; m1_wdata = d; m1_type = t;
    endtask

    // One cycle: drive requests, check grant and DM fields, queue the response.
    task automatic tick(input bit r0, input bit r1, input bit eg0, input bit eg1,
                        input bit xerr, input logic [31:0] xrd);
        exp_t        e;
        bit          we;
        logic [31:0] ad, wd;
        logic [2:0]  ty;
        m0_req = r0;
        m1_req = r1;
        @(negedge clk);
        chk("gnt", {94'd0, m0_gnt, m1_gnt}, {94'd0, eg0, eg1});
        if (eg0 || eg1) begin
            we = eg1 ? m1_we    : m0_we;
            ad = eg1 ? m1_addr  : m0_addr;
            wd = eg1 ? m1_wdata : m0_wdata;
            ty = eg1 ? m1_type  : m0_type;
            chk("strobe", {94'd0, dm_MemWrite, dm_MemRead},
                {94'd0, (xerr ? 2'b00 : (we ? 2'b10 : 2'b01))});
            if (!xerr)
                chk("dm_fields", {29'd0, dm_addr, dm_din, dm_DMType},
                    {29'd0, ad, wd, ty});
            e.port = eg1; e.err = xerr; e.rd = xrd; e.due = cyc + 1;
            sb.push_back(e);
        end else begin
            chk("dm_idle", {29'd0, dm_MemWrite, dm_MemRead, dm_addr, dm_din, dm_DMType},
                96'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_clr = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        set0(1'b0, 32'd0, 32'd0, W);
        set1(1'b0, 32'd0, 32'd0, W);
        @(posedge clk);
        #1;
        // Reset holds everything at zero even with both requests high.
        tick(1, 1, 0, 0, 0, 32'd0);
        tick(1, 1, 0, 0, 0, 32'd0);
        rst = 1'b0;
        mem_clr = 1'b0;

        // Store then load word at 8.
        set0(1'b1, 32'd8, 32'hDEADBEEF, W); tick(1, 0, 1, 0, 0, 32'd0);
        set0(1'b0, 32'd8, 32'd0, W);        tick(1, 0, 1, 0, 0, 32'hDEADBEEF);

        // Sign/zero extension of sub-word loads.
        set0(1'b1, 32'd4, 32'h000080FF, W); tick(1, 0, 1, 0, 0, 32'd0);
        set0(1'b0, 32'd4, 32'd0, B);        tick(1, 0, 1, 0, 0, 32'hFFFFFFFF);
        set0(1'b0, 32'd4, 32'd0, BU);       tick(1, 0, 1, 0, 0, 32'h000000FF);
        set0(1'b0, 32'd4, 32'd0, H);        tick(1, 0, 1, 0, 0, 32'hFFFF80FF);
        set0(1'b0, 32'd4, 32'd0, HU);       tick(1, 0, 1, 0, 0, 32'h000080FF);

        // Continuous contention: m0 x4 then m1, repeating.
        set0(1'b0, 32'd8, 32'd0, W);
        set1(1'b0, 32'd4, 32'd0, W);
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) tick(1, 1, 0, 1, 0, 32'h000080FF);
            else            tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        end
        tick(0, 0, 0, 0, 0, 32'd0);

        // Illegal accesses: misaligned, out of range, wrap, bad type.
        set0(1'b1, 32'd2, 32'h55555555, W);  tick(1, 0, 1, 0, 1, 32'd0);
        set0(1'b1, 32'd127, 32'h0000AAAA, H); tick(1, 0, 1, 0, 1, 32'd0);
        set0(1'b1, 32'hFFFFFFFC, 32'h11223344, W); tick(1, 0, 1, 0, 1, 32'd0);
        set0(1'b1, 32'd0, 32'h12345678, 3'b111);   tick(1, 0, 1, 0, 1, 32'd0);
        set1(1'b1, 32'd128, 32'h99999999, B);      tick(0, 1, 0, 1, 1, 32'd0);
        // Memory untouched by the rejected stores.
        set0(1'b0, 32'd0, 32'd0, W);   tick(1, 0, 1, 0, 0, 32'd0);
        set0(1'b0, 32'd124, 32'd0, W); tick(1, 0, 1, 0, 0, 32'd0);
        set0(1'b0, 32'd127, 32'd0, BU); tick(1, 0, 1, 0, 0, 32'd0);
        set0(1'b0, 32'd8, 32'd0, W);   tick(1, 0, 1, 0, 0, 32'hDEADBEEF);
        // Legal sub-word store through port 1 near the top of memory.
        set1(1'b1, 32'd125, 32'h0000005A, B); tick(0, 1, 0, 1, 0, 32'd0);
        set0(1'b0, 32'd125, 32'd0, BU);       tick(1, 0, 1, 0, 0, 32'h0000005A);

        // Reset while port 1 has starved 3 cycles: count must restart.
        set0(1'b0, 32'd8, 32'd0, W);
        set1(1'b0, 32'd4, 32'd0, W);
        tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        void'(sb.pop_back());
        rst = 1'b1;
        tick(1, 1, 0, 0, 0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) tick(1, 1, 0, 1, 0, 32'h000080FF);
            else        tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        end

        // Port 1 load accepted, reset on the next edge: response discarded.
        tick(0, 1, 0, 1, 0, 32'h000080FF);
        void'(sb.pop_back());
        rst = 1'b1;
        tick(0, 0, 0, 0, 0, 32'd0);
        rst = 1'b0;
        tick(0, 0, 0, 0, 0, 32'd0);

        // Port 1 drops its request after 2 denials: full wait next time.
        tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        tick(1, 0, 1, 0, 0, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) tick(1, 1, 0, 1, 0, 32'h000080FF);
            else        tick(1, 1, 1, 0, 0, 32'hDEADBEEF);
        end
        tick(0, 0, 0, 0, 0, 32'd0);
        tick(0, 0, 0, 0, 0, 32'd0);

        chk("sb_drained", 96'(sb.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
